// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if
// Groups every signal between the trap sequencer and its surroundings
// (execute stage, interrupt lines, CSR file, fetch control).
//   slave  : seen by trap_sequencer (requests/CSR state in, CSR port/control out)
//   master : seen by the core side driving requests and consuming the outputs
// state_dbg exposes the sequencer FSM state for checkers and debug.
// Handshake: a request (exc_valid/irq/is_mret) is taken only in the cycle it is
// presented while busy=0; there is no ready, and a request that is not taken is
// simply dropped, so the core must keep presenting it until it sees the trap.
interface trap_sequencer_if #(
    parameter int XLEN = 32
);
    logic            exc_valid;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] cur_pc;
    logic            irq_ext;
    logic            irq_tmr;
    logic            is_mret;
    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic            core_csr_wr;
    logic [11:0]     core_csr_addr;
    logic [XLEN-1:0] core_csr_wdata;
    logic            csr_wr;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;
    logic [2:0]      state_dbg;

    modport slave (
        input  exc_valid, exc_cause, exc_pc, cur_pc, irq_ext, irq_tmr, is_mret,
               mstatus_q, mie_q, mtvec_q, mepc_q,
               core_csr_wr, core_csr_addr, core_csr_wdata,
        output csr_wr, csr_addr, csr_wdata, stall, flush,
               redirect_valid, redirect_pc, busy, state_dbg
    );

    modport master (
        output exc_valid, exc_cause, exc_pc, cur_pc, irq_ext, irq_tmr, is_mret,
               mstatus_q, mie_q, mtvec_q, mepc_q,
               core_csr_wr, core_csr_addr, core_csr_wdata,
        input  csr_wr, csr_addr, csr_wdata, stall, flush,
               redirect_valid, redirect_pc, busy, state_dbg
    );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer
// Machine-mode trap entry / MRET return sequencer for the 3-stage pipeline.
// Picks one of exception > external irq > timer irq > MRET while idle, stalls
// the pipeline for DRAIN_CYCLES, writes mepc/mcause/mstatus (trap) or mstatus
// (MRET) one per cycle through the CSR write mux, then redirects fetch with a
// one-cycle flush.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   seq_if.slave : requests, CSR state, core CSR write in; muxed CSR write,
//                  stall/flush/redirect/busy and state_dbg out
// Optional build macro: TRAP_SEQ_VECTORED_EN enables vectored interrupt targets
// (mtvec mode 01 -> base + 4*cause).
module trap_sequencer #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 1
) (
    input logic             clk,
    input logic             rst,
    trap_sequencer_if.slave seq_if
);
    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_W_MEPC, S_W_MCAUSE, S_W_STATUS, S_M_STATUS, S_REDIRECT
    } state_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [2:0]  DRAIN_LAST   = (DRAIN_CYCLES > 0) ? 3'(DRAIN_CYCLES - 1) : 3'd0;

    state_t          state_q, state_d;
    logic [2:0]      drain_cnt_q, drain_cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic            mret_q, mret_d;
    logic            stall_q, flush_q, redirect_q;

    logic            int_ext, int_tmr, idle;
    logic [XLEN-1:0] mstatus_trap, mstatus_mret, trap_base, trap_target;
    logic            fsm_wr;
    logic [11:0]     fsm_addr;
    logic [XLEN-1:0] fsm_wdata;
    logic            unused_bits;

    assign int_ext = seq_if.irq_ext & seq_if.mie_q[11] & seq_if.mstatus_q[3];
    assign int_tmr = seq_if.irq_tmr & seq_if.mie_q[7] & seq_if.mstatus_q[3];
    assign idle    = (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        pc_d        = pc_q;
        cause_d     = cause_q;
        mret_d      = mret_q;
        case (state_q)
            S_IDLE: begin
                if (seq_if.exc_valid || int_ext || int_tmr || seq_if.is_mret) begin
                    drain_cnt_d = '0;
                    mret_d      = 1'b0;
                    if (seq_if.exc_valid) begin
                        pc_d          = seq_if.exc_pc;
                        cause_d       = '0;
                        cause_d[3:0]  = seq_if.exc_cause;
                    end else if (int_ext) begin
                        pc_d            = seq_if.cur_pc;
                        cause_d         = '0;
                        cause_d[XLEN-1] = 1'b1;
                        cause_d[3:0]    = 4'hB;
                    end else if (int_tmr) begin
                        pc_d            = seq_if.cur_pc;
                        cause_d         = '0;
                        cause_d[XLEN-1] = 1'b1;
                        cause_d[3:0]    = 4'h7;
                    end else begin
                        // MRET keeps pc/cause untouched; only the path flag changes.
                        mret_d = 1'b1;
                    end
                    if (DRAIN_CYCLES == 0) begin
                        state_d = mret_d ? S_M_STATUS : S_W_MEPC;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    state_d     = mret_q ? S_M_STATUS : S_W_MEPC;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            S_W_MEPC:   state_d = S_W_MCAUSE;
            S_W_MCAUSE: state_d = S_W_STATUS;
            S_W_STATUS: state_d = S_REDIRECT;
            S_M_STATUS: state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up
    // exactly with state_q and drop to 0 the instant reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            pc_q        <= '0;
            cause_q     <= '0;
            mret_q      <= 1'b0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            pc_q        <= pc_d;
            cause_q     <= cause_d;
            mret_q      <= mret_d;
            stall_q     <= (state_d != S_IDLE);
            flush_q     <= (state_d == S_REDIRECT);
            redirect_q  <= (state_d == S_REDIRECT);
        end
    end

    // mstatus images use the live mstatus_q so a core write landing in the
    // accept cycle is still honoured.
    always_comb begin
        mstatus_trap        = seq_if.mstatus_q;
        mstatus_trap[7]     = seq_if.mstatus_q[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
        mstatus_mret        = seq_if.mstatus_q;
        mstatus_mret[3]     = seq_if.mstatus_q[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;
    end

    always_comb begin
        fsm_wr    = 1'b0;
        fsm_addr  = '0;
        fsm_wdata = '0;
        case (state_q)
            S_W_MEPC: begin
                fsm_wr    = 1'b1;
                fsm_addr  = ADDR_MEPC;
                fsm_wdata = {pc_q[XLEN-1:2], 2'b00};
            end
            S_W_MCAUSE: begin
                fsm_wr    = 1'b1;
                fsm_addr  = ADDR_MCAUSE;
                fsm_wdata = cause_q;
            end
            S_W_STATUS: begin
                fsm_wr    = 1'b1;
                fsm_addr  = ADDR_MSTATUS;
                fsm_wdata = mstatus_trap;
            end
            S_M_STATUS: begin
                fsm_wr    = 1'b1;
                fsm_addr  = ADDR_MSTATUS;
                fsm_wdata = mstatus_mret;
            end
            default: ;
        endcase
    end

    assign trap_base = {seq_if.mtvec_q[XLEN-1:2], 2'b00};
`ifdef TRAP_SEQ_VECTORED_EN
    // Only interrupts vector; exceptions always land on the base.
    assign trap_target = (cause_q[XLEN-1] && seq_if.mtvec_q[1:0] == 2'b01)
                       ? trap_base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00}
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    // Idle: core CSR writes pass straight through (forced off during reset).
    assign seq_if.csr_wr    = idle ? (seq_if.core_csr_wr & ~rst) : fsm_wr;
    assign seq_if.csr_addr  = idle ? (rst ? 12'd0 : seq_if.core_csr_addr) : fsm_addr;
    assign seq_if.csr_wdata = idle ? (rst ? '0 : seq_if.core_csr_wdata) : fsm_wdata;

    assign seq_if.stall          = stall_q;
    assign seq_if.busy           = stall_q;
    assign seq_if.flush          = flush_q;
    assign seq_if.redirect_valid = redirect_q;
    assign seq_if.redirect_pc    = !redirect_q ? '0
                                 : mret_q ? {seq_if.mepc_q[XLEN-1:2], 2'b00}
                                 : trap_target;
    assign seq_if.state_dbg      = state_q;

    assign unused_bits = ^{pc_q[1:0], seq_if.mepc_q[1:0], seq_if.mtvec_q[1:0], seq_if.mie_q};
endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;
    localparam int XLEN  = 32;
    localparam int DRAIN = 1;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    trap_sequencer_if #(.XLEN(XLEN)) bus_if();

    trap_sequencer #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN)) dut (
        .clk    (clk),
        .rst    (rst),
        .seq_if (bus_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic clear_requests();
        bus_if.exc_valid   = 1'b0;
        bus_if.irq_ext     = 1'b0;
        bus_if.irq_tmr     = 1'b0;
        bus_if.is_mret     = 1'b0;
        bus_if.core_csr_wr = 1'b0;
    endtask

    task automatic init_inputs();
        clear_requests();
        bus_if.exc_cause      = 4'd0;
        bus_if.exc_pc         = '0;
        bus_if.cur_pc         = '0;
        bus_if.mstatus_q      = '0;
        bus_if.mie_q          = '0;
        bus_if.mtvec_q        = '0;
        bus_if.mepc_q         = '0;
        bus_if.core_csr_addr  = '0;
        bus_if.core_csr_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives the currently-set inputs for one accept cycle and follows the
    // resulting sequence against the reference model's expected write queue.
    task automatic run_and_check(input string name);
        logic [43:0] exp_q[$];
        logic [43:0] got;
        logic [43:0] expd;
        logic [31:0] ms, pc, cause, target;
        int          kind, lat, wr_idx;
        bit          seen;

        // ---- reference model: priority, captured values, expected writes ----
        ms   = bus_if.mstatus_q;
        kind = 0;
        if (bus_if.exc_valid) kind = 1;
        else if (bus_if.irq_ext && bus_if.mie_q[11] && ms[3]) kind = 2;
        else if (bus_if.irq_tmr && bus_if.mie_q[7] && ms[3]) kind = 3;
        else if (bus_if.is_mret) kind = 4;

        pc    = (kind == 1) ? bus_if.exc_pc : bus_if.cur_pc;
        cause = (kind == 1) ? {28'd0, bus_if.exc_cause}
              : (kind == 2) ? 32'h8000_000B : 32'h8000_0007;
        lat   = 0;
        if (kind == 4) begin
            exp_q.push_back({12'h300, (ms & ~32'h1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h1880});
            lat    = DRAIN + 2;
            target = bus_if.mepc_q & ~32'h3;
        end else begin
            exp_q.push_back({12'h341, pc & ~32'h3});
            exp_q.push_back({12'h342, cause});
            exp_q.push_back({12'h300, (ms & ~32'h1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800});
            lat    = DRAIN + 4;
            target = bus_if.mtvec_q & ~32'h3;
`ifdef TRAP_SEQ_VECTORED_EN
            if ((kind == 2 || kind == 3) && bus_if.mtvec_q[1:0] == 2'b01)
                target = target + (cause & 32'hF) * 4;
`endif
        end

        // ---- accept cycle: still idle, core write mirrored ----
        @(negedge clk);
        n_checks++;
        if (bus_if.busy !== 1'b0 || bus_if.stall !== 1'b0) begin
            $display("FAIL %s accept_idle: busy=%b stall=%b required 0/0", name, bus_if.busy, bus_if.stall);
        end else n_pass++;
        n_checks++;
        if ({bus_if.csr_wr, bus_if.csr_addr, bus_if.csr_wdata} !==
            {bus_if.core_csr_wr, bus_if.core_csr_addr, bus_if.core_csr_wdata}) begin
            $display("FAIL %s passthrough: got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                     name, bus_if.csr_wr, bus_if.csr_addr, bus_if.csr_wdata,
                     bus_if.core_csr_wr, bus_if.core_csr_addr, bus_if.core_csr_wdata);
        end else n_pass++;
        next_cycle();
        clear_requests();

        if (kind == 0) begin
            @(negedge clk);
            n_checks++;
            if (bus_if.busy !== 1'b0 || bus_if.redirect_valid !== 1'b0) begin
                $display("FAIL %s no_accept: busy=%b redirect_valid=%b required 0/0",
                         name, bus_if.busy, bus_if.redirect_valid);
            end else n_pass++;
            return;
        end

        seen   = 0;
        wr_idx = 0;
        for (int k = 1; k <= lat + 3 && !seen; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus_if.stall !== 1'b1 || bus_if.busy !== 1'b1) begin
                $display("FAIL %s stall_cycle%0d: stall=%b busy=%b required 1/1",
                         name, k, bus_if.stall, bus_if.busy);
            end else n_pass++;
            if (bus_if.csr_wr === 1'b1) begin
                got = {bus_if.csr_addr, bus_if.csr_wdata};
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s extra_write: cycle %0d got addr=%h data=%h required none",
                             name, k, bus_if.csr_addr, bus_if.csr_wdata);
                end else begin
                    expd = exp_q.pop_front();
                    if (got !== expd || k != DRAIN + 1 + wr_idx) begin
                        $display("FAIL %s csr_write%0d: cycle %0d got %h/%h required cycle %0d %h/%h",
                                 name, wr_idx, k, got[43:32], got[31:0],
                                 DRAIN + 1 + wr_idx, expd[43:32], expd[31:0]);
                    end else n_pass++;
                    wr_idx++;
                end
            end
            if (bus_if.redirect_valid === 1'b1) begin
                seen = 1;
                n_checks++;
                if (k != lat || bus_if.redirect_pc !== target || bus_if.flush !== 1'b1) begin
                    $display("FAIL %s redirect: cycle %0d pc=%h flush=%b required cycle %0d pc=%h flush=1",
                             name, k, bus_if.redirect_pc, bus_if.flush, lat, target);
                end else n_pass++;
            end
        end
        n_checks++;
        if (!seen || exp_q.size() != 0) begin
            $display("FAIL %s completion: redirect_seen=%0d writes_left=%0d required 1/0",
                     name, seen, exp_q.size());
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus_if.busy !== 1'b0 || bus_if.redirect_valid !== 1'b0 || bus_if.flush !== 1'b0) begin
            $display("FAIL %s back_to_idle: busy=%b redirect_valid=%b flush=%b required 0/0/0",
                     name, bus_if.busy, bus_if.redirect_valid, bus_if.flush);
        end else n_pass++;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        bus_if.core_csr_wr    = 1'b1;
        bus_if.core_csr_addr  = 12'h305;
        bus_if.core_csr_wdata = 32'h200;
        @(negedge clk);
        n_checks++;
        if ({bus_if.csr_wr, bus_if.csr_addr, bus_if.csr_wdata, bus_if.stall, bus_if.flush,
             bus_if.redirect_valid, bus_if.redirect_pc, bus_if.busy} !== '0) begin
            $display("FAIL reset_outputs: wr=%b stall=%b flush=%b rv=%b pc=%h busy=%b required all 0",
                     bus_if.csr_wr, bus_if.stall, bus_if.flush, bus_if.redirect_valid,
                     bus_if.redirect_pc, bus_if.busy);
        end else n_pass++;
        next_cycle();
        clear_requests();
        rst = 1'b0;
    endtask

    task automatic test_timer();
        next_cycle();
        bus_if.mstatus_q = 32'h8;
        bus_if.mie_q     = 32'h80;
        bus_if.mtvec_q   = 32'h100;
        bus_if.cur_pc    = 32'h40;
        bus_if.irq_tmr   = 1'b1;
        run_and_check("timer_irq");
    endtask

    task automatic test_priority();
        next_cycle();
        bus_if.mstatus_q      = 32'h8;
        bus_if.mie_q          = 32'h880;
        bus_if.mtvec_q        = 32'h200;
        bus_if.cur_pc         = 32'h60;
        bus_if.exc_valid      = 1'b1;
        bus_if.exc_cause      = 4'd2;
        bus_if.exc_pc         = 32'h24;
        bus_if.irq_ext        = 1'b1;
        bus_if.irq_tmr        = 1'b1;
        bus_if.core_csr_wr    = 1'b1;
        bus_if.core_csr_addr  = 12'h340;
        bus_if.core_csr_wdata = 32'hABCD;
        run_and_check("exc_over_irq");
    endtask

    task automatic test_mret();
        next_cycle();
        bus_if.mstatus_q = 32'h1880;
        bus_if.mepc_q    = 32'h44;
        bus_if.is_mret   = 1'b1;
        run_and_check("mret");
    endtask

    task automatic test_no_accept();
        next_cycle();
        bus_if.mstatus_q      = 32'h0;
        bus_if.mie_q          = 32'h80;
        bus_if.irq_tmr        = 1'b1;
        bus_if.core_csr_wr    = 1'b1;
        bus_if.core_csr_addr  = 12'h305;
        bus_if.core_csr_wdata = 32'h200;
        run_and_check("masked_timer");
    endtask

    task automatic test_reset_mid();
        bit bad;
        next_cycle();
        bus_if.mstatus_q = 32'h8;
        bus_if.mie_q     = 32'h80;
        bus_if.mtvec_q   = 32'h100;
        bus_if.cur_pc    = 32'h40;
        bus_if.irq_tmr   = 1'b1;
        next_cycle();   // accept edge -> DRAIN
        clear_requests();
        next_cycle();   // -> W_MEPC
        next_cycle();   // -> W_MCAUSE
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_if.csr_wr, bus_if.csr_addr, bus_if.csr_wdata, bus_if.stall, bus_if.flush,
             bus_if.redirect_valid, bus_if.redirect_pc, bus_if.busy} !== '0) begin
            $display("FAIL reset_mid_outputs: wr=%b addr=%h stall=%b rv=%b busy=%b required all 0",
                     bus_if.csr_wr, bus_if.csr_addr, bus_if.stall, bus_if.redirect_valid, bus_if.busy);
        end else n_pass++;
        next_cycle();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus_if.redirect_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.csr_wr !== 1'b0)
                bad = 1;
        end
        n_checks++;
        if (bad) $display("FAIL reset_mid_quiet: activity seen after reset, required none");
        else n_pass++;
        test_timer();
    endtask

    task automatic test_vectored();
        next_cycle();
        bus_if.mstatus_q = 32'h8;
        bus_if.mie_q     = 32'h800;
        bus_if.mtvec_q   = 32'h101;
        bus_if.cur_pc    = 32'h80;
        bus_if.irq_ext   = 1'b1;
        run_and_check("ext_mtvec_101");
        next_cycle();
        bus_if.mtvec_q   = 32'h100;
        bus_if.irq_ext   = 1'b1;
        run_and_check("ext_mtvec_100");
    endtask

    task automatic test_random();
        logic [31:0] mie_opts[4];
        mie_opts[0] = 32'h0;
        mie_opts[1] = 32'h80;
        mie_opts[2] = 32'h800;
        mie_opts[3] = 32'h880;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            bus_if.exc_valid      = ($urandom_range(0, 3) == 0);
            bus_if.exc_cause      = 4'($urandom_range(0, 15));
            bus_if.exc_pc         = $urandom;
            bus_if.cur_pc         = $urandom;
            bus_if.irq_ext        = 1'($urandom_range(0, 1));
            bus_if.irq_tmr        = 1'($urandom_range(0, 1));
            bus_if.is_mret        = 1'($urandom_range(0, 1));
            bus_if.mstatus_q      = $urandom;
            bus_if.mie_q          = mie_opts[$urandom_range(0, 3)] | ($urandom & 32'hFFFF_F77F);
            bus_if.mtvec_q        = $urandom;
            bus_if.mepc_q         = $urandom;
            bus_if.core_csr_wr    = 1'($urandom_range(0, 1));
            bus_if.core_csr_addr  = 12'($urandom_range(0, 4095));
            bus_if.core_csr_wdata = $urandom;
            run_and_check("random");
        end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        rst = 1'b1;
        init_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_timer();
        test_priority();
        test_mret();
        test_no_accept();
        test_reset_mid();
        test_vectored();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
